// File: rtl/mips_execute_alu_operand_stage_if.sv
// Handshake and bus bundle for the ID/EX ALU operand stage.
// Ports: decode-side in_*, writeback forward fwd_*, flush, ALU-side out_*.
interface mips_execute_alu_operand_stage_if #(
  parameter int WIDTH          = 32,
  parameter int ALU_OP_WIDTH   = 4,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [REG_ADDR_WIDTH-1:0] in_rs;
  logic [REG_ADDR_WIDTH-1:0] in_rt;
  logic [WIDTH-1:0]          in_data1;
  logic [WIDTH-1:0]          in_data2;
  logic [15:0]               in_immediate;
  logic [4:0]                in_shamt;
  logic                      in_signExtend;
  logic [1:0]                in_data2Source;
  logic [ALU_OP_WIDTH-1:0]   in_aluOp;
  logic [REG_ADDR_WIDTH-1:0] in_dest;
  logic                      fwd_valid;
  logic [REG_ADDR_WIDTH-1:0] fwd_reg;
  logic [WIDTH-1:0]          fwd_data;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_operandA;
  logic [WIDTH-1:0]          out_operandB;
  logic [ALU_OP_WIDTH-1:0]   out_aluOp;
  logic [REG_ADDR_WIDTH-1:0] out_dest;

  modport master (
    output in_valid, in_rs, in_rt, in_data1, in_data2,
    output in_immediate, in_shamt, in_signExtend,
    output in_data2Source, in_aluOp, in_dest,
    output fwd_valid, fwd_reg, fwd_data, flush, out_ready,
    input  in_ready, out_valid, out_operandA, out_operandB,
    input  out_aluOp, out_dest
  );

  modport slave (
    input  in_valid, in_rs, in_rt, in_data1, in_data2,
    input  in_immediate, in_shamt, in_signExtend,
    input  in_data2Source, in_aluOp, in_dest,
    input  fwd_valid, fwd_reg, fwd_data, flush, out_ready,
    output in_ready, out_valid, out_operandA, out_operandB,
    output out_aluOp, out_dest
  );
endinterface

// File: rtl/mips_execute_alu_operand_stage.sv
// ID/EX operand stage: resolves ALU operands at capture, 2-entry skid FIFO.
// Ports: clock, reset (async high), bus (slave view of the stage interface).
module mips_execute_alu_operand_stage #(
  parameter int WIDTH          = 32,
  parameter int ALU_OP_WIDTH   = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic clock,
  input logic reset,
  mips_execute_alu_operand_stage_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0]          a;
    logic [WIDTH-1:0]          b;
    logic [ALU_OP_WIDTH-1:0]   op;
    logic [REG_ADDR_WIDTH-1:0] dest;
  } entry_t;

  logic [1:0] r_count;
  logic       r_in_ready;
  entry_t     r_head;
  entry_t     r_tail;

  logic       w_fwd_a;
  logic       w_fwd_b;
  logic       w_accept;
  logic       w_pop;
  logic [WIDTH-1:0] w_imm;
  logic [WIDTH-1:0] w_shamt;
  entry_t     w_new;

  // Operands are resolved once, from the inputs, on the way in.
  always_comb begin
    w_fwd_a = bus.fwd_valid && (bus.fwd_reg == bus.in_rs)
           && (bus.in_rs != '0);
    w_fwd_b = bus.fwd_valid && (bus.fwd_reg == bus.in_rt)
           && (bus.in_rt != '0);
    w_imm   = {{(WIDTH-16){bus.in_signExtend & bus.in_immediate[15]}},
               bus.in_immediate};
    w_shamt = {{(WIDTH-5){1'b0}}, bus.in_shamt};
    w_new.a    = w_fwd_a ? bus.fwd_data : bus.in_data1;
    w_new.op   = bus.in_aluOp;
    w_new.dest = bus.in_dest;
    case (bus.in_data2Source)
      2'd0:    w_new.b = w_fwd_b ? bus.fwd_data : bus.in_data2;
      2'd2:    w_new.b = w_shamt;
      default: w_new.b = w_imm;
    endcase
  end

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_pop    = (r_count != 2'd0) && bus.out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (bus.flush) begin
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      unique case (1'b1)
        (w_accept && w_pop): begin
          // Head leaves; tail (if any) moves up, new entry goes behind it.
          if (r_count == 2'd2) begin
            r_head <= r_tail;
            r_tail <= w_new;
          end else begin
            r_head <= w_new;
          end
        end
        (w_accept && !w_pop): begin
          if (r_count == 2'd0) r_head <= w_new;
          else                 r_tail <= w_new;
          r_count    <= r_count + 2'd1;
          r_in_ready <= (r_count == 2'd0);
        end
        (!w_accept && w_pop): begin
          if (r_count == 2'd2) r_head <= r_tail;
          r_count    <= r_count - 2'd1;
          r_in_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = (r_count != 2'd0);
  assign bus.out_operandA = r_head.a;
  assign bus.out_operandB = r_head.b;
  assign bus.out_aluOp    = r_head.op;
  assign bus.out_dest     = r_head.dest;

endmodule

// File: tb/tb_mips_execute_alu_operand_stage.sv
// Testbench for mips_execute_alu_operand_stage: vector table, corner
// sequences and randomized traffic against a queue-based model.
module tb_mips_execute_alu_operand_stage;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mips_execute_alu_operand_stage_if #(32, 4, 5) bus ();

  mips_execute_alu_operand_stage #(
    .WIDTH(32), .ALU_OP_WIDTH(4), .REG_ADDR_WIDTH(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  typedef struct {
    logic [4:0]  rs, rt;
    logic [31:0] d1, d2;
    logic [15:0] imm;
    logic [4:0]  sh;
    logic        sx;
    logic [1:0]  src;
    logic        fv;
    logic [4:0]  freg;
    logic [31:0] fdata;
    logic [3:0]  op;
    logic [4:0]  dest;
    logic [31:0] ea, eb;
  } vec_t;

  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [4:0]  dest;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic [4:0] rs, logic [4:0] rt, logic [31:0] d1, logic [31:0] d2,
    logic [15:0] imm, logic [4:0] sh, logic sx, logic [1:0] src,
    logic fv, logic [4:0] freg, logic [31:0] fdata,
    logic [3:0] op, logic [4:0] dest, logic [31:0] ea, logic [31:0] eb);
    vec_t v;
    v.rs = rs; v.rt = rt; v.d1 = d1; v.d2 = d2; v.imm = imm; v.sh = sh;
    v.sx = sx; v.src = src; v.fv = fv; v.freg = freg; v.fdata = fdata;
    v.op = op; v.dest = dest; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  // Reference: operand rules stated directly as arithmetic.
  function automatic exp_t model(vec_t v);
    exp_t e;
    logic signed [15:0] simm;
    bit hit_a, hit_b;
    simm  = v.imm;
    hit_a = v.fv && v.freg == v.rs && v.rs != 0;
    hit_b = v.fv && v.freg == v.rt && v.rt != 0;
    e.a = hit_a ? v.fdata : v.d1;
    if (v.src == 2'd0)      e.b = hit_b ? v.fdata : v.d2;
    else if (v.src == 2'd2) e.b = 32'(v.sh);
    else if (v.sx)          e.b = 32'(simm);
    else                    e.b = 32'(v.imm);
    e.op = v.op;
    e.dest = v.dest;
    return e;
  endfunction

  task automatic drive(vec_t v, logic valid);
    bus.in_valid       = valid;
    bus.in_rs          = v.rs;
    bus.in_rt          = v.rt;
    bus.in_data1       = v.d1;
    bus.in_data2       = v.d2;
    bus.in_immediate   = v.imm;
    bus.in_shamt       = v.sh;
    bus.in_signExtend  = v.sx;
    bus.in_data2Source = v.src;
    bus.in_aluOp       = v.op;
    bus.in_dest        = v.dest;
    bus.fwd_valid      = v.fv;
    bus.fwd_reg        = v.freg;
    bus.fwd_data       = v.fdata;
  endtask

  function automatic vec_t rnd_vec();
    vec_t v;
    v.rs = 5'($urandom_range(0, 3));
    v.rt = 5'($urandom_range(0, 3));
    v.d1 = $urandom;
    v.d2 = $urandom;
    v.imm = 16'($urandom);
    v.sh = 5'($urandom);
    v.sx = 1'($urandom);
    v.src = 2'($urandom);
    v.fv = 1'($urandom);
    v.freg = 5'($urandom_range(0, 3));
    v.fdata = $urandom;
    v.op = 4'($urandom);
    v.dest = 5'($urandom);
    v.ea = '0;
    v.eb = '0;
    return v;
  endfunction

  vec_t tbl[10];
  vec_t z, i0, i1;
  exp_t q[$];
  exp_t e;
  logic m_ready;

  initial begin
    z = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    tbl[0] = mk(1,2,32'h11111111,32'hDEADBEEF,16'h0,5'd31,0,2'd2,
                0,0,0,4'h3,5'd4,32'h11111111,32'h0000001F);
    tbl[1] = mk(1,2,32'hAAAA0000,32'h0,16'h8001,0,1,2'd1,
                0,0,0,4'h1,5'd5,32'hAAAA0000,32'hFFFF8001);
    tbl[2] = mk(1,2,32'hAAAA0001,32'h0,16'h8001,0,0,2'd1,
                0,0,0,4'h2,5'd6,32'hAAAA0001,32'h00008001);
    tbl[3] = mk(1,2,32'hAAAA0002,32'h0,16'h8001,0,1,2'd3,
                0,0,0,4'h4,5'd7,32'hAAAA0002,32'hFFFF8001);
    tbl[4] = mk(1,2,32'hAAAA0003,32'h0,16'h8001,0,0,2'd3,
                0,0,0,4'h5,5'd8,32'hAAAA0003,32'h00008001);
    tbl[5] = mk(8,8,32'h1,32'h2,0,0,0,2'd0,
                1,8,32'h12345678,4'h6,5'd9,32'h12345678,32'h12345678);
    tbl[6] = mk(0,0,32'hCAFE0001,32'hCAFE0002,0,0,0,2'd0,
                1,0,32'h12345678,4'h7,5'd10,32'hCAFE0001,32'hCAFE0002);
    tbl[7] = mk(3,8,32'h33333333,32'h44444444,0,0,0,2'd0,
                1,8,32'h55555555,4'h8,5'd11,32'h33333333,32'h55555555);
    tbl[8] = mk(8,8,32'h66666666,32'h77777777,0,0,0,2'd0,
                0,8,32'h55555555,4'h9,5'd12,32'h66666666,32'h77777777);
    tbl[9] = mk(8,1,32'h0,32'h0,16'h007F,0,1,2'd1,
                1,8,32'h99999999,4'hA,5'd13,32'h99999999,32'h0000007F);
    i0 = mk(1,2,32'hA0A0A0A0,32'hB0B0B0B0,0,0,0,2'd0,
            0,0,0,4'h1,5'd1,0,0);
    i1 = mk(1,2,32'hC0C0C0C0,32'hD0D0D0D0,0,0,0,2'd0,
            0,0,0,4'h2,5'd2,0,0);

    drive(z, 1'b0);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_in_ready", 32'(bus.in_ready), 1);
    chk("reset_opA", bus.out_operandA, 0);
    chk("reset_opB", bus.out_operandB, 0);
    reset = 1'b0;

    // Vector table: one accept per cycle, ALU always ready.
    @(negedge clock);
    drive(tbl[0], 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 1);
      chk($sformatf("vec%0d_opA", i), bus.out_operandA, tbl[i].ea);
      chk($sformatf("vec%0d_opB", i), bus.out_operandB, tbl[i].eb);
      chk($sformatf("vec%0d_op", i), 32'(bus.out_aluOp), 32'(tbl[i].op));
      if (i < 9) drive(tbl[i+1], 1'b1);
      else       drive(z, 1'b0);
    end
    @(negedge clock);
    chk("drain_valid", 32'(bus.out_valid), 0);

    // Backpressure: fill both slots, then release in order.
    bus.out_ready = 1'b0;
    drive(i0, 1'b1);
    @(negedge clock);
    chk("bp_ready1", 32'(bus.in_ready), 1);
    drive(i1, 1'b1);
    @(negedge clock);
    chk("bp_ready_full", 32'(bus.in_ready), 0);
    drive(z, 1'b1);
    @(negedge clock);
    chk("bp_hold_opA", bus.out_operandA, 32'hA0A0A0A0);
    chk("bp_still_full", 32'(bus.in_ready), 0);
    drive(z, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("bp_second_opA", bus.out_operandA, 32'hC0C0C0C0);
    chk("bp_second_dest", 32'(bus.out_dest), 2);
    chk("bp_ready_back", 32'(bus.in_ready), 1);
    @(negedge clock);
    chk("bp_empty", 32'(bus.out_valid), 0);

    // Flush with two held entries and a concurrent input.
    bus.out_ready = 1'b0;
    drive(i0, 1'b1);
    @(negedge clock);
    drive(i1, 1'b1);
    @(negedge clock);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    drive(z, 1'b0);
    chk("flush2_valid", 32'(bus.out_valid), 0);
    chk("flush2_ready", 32'(bus.in_ready), 1);
    @(negedge clock);
    chk("flush2_stays", 32'(bus.out_valid), 0);

    // Flush while ready: the concurrent accept is discarded.
    drive(i0, 1'b1);
    @(negedge clock);
    drive(i1, 1'b1);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    drive(z, 1'b0);
    chk("flush1_valid", 32'(bus.out_valid), 0);
    @(negedge clock);
    chk("flush1_no_emit", 32'(bus.out_valid), 0);

    // Asynchronous reset with two entries held.
    bus.out_ready = 1'b0;
    drive(i0, 1'b1);
    @(negedge clock);
    drive(i1, 1'b1);
    @(negedge clock);
    drive(z, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", 32'(bus.out_valid), 0);
    chk("areset_ready", 32'(bus.in_ready), 1);
    chk("areset_opA", bus.out_operandA, 0);
    chk("areset_opB", bus.out_operandB, 0);
    chk("areset_op", 32'(bus.out_aluOp), 0);
    chk("areset_dest", 32'(bus.out_dest), 0);
    @(negedge clock);
    reset = 1'b0;

    // Randomized traffic against the queue model.
    m_ready = 1'b1;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      vec_t v;
      logic acc, pop;
      @(negedge clock);
      chk("rnd_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("rnd_in_ready", 32'(bus.in_ready), 32'(m_ready));
      if (q.size() != 0 && bus.out_valid) begin
        chk("rnd_opA", bus.out_operandA, q[0].a);
        chk("rnd_opB", bus.out_operandB, q[0].b);
        chk("rnd_op", 32'(bus.out_aluOp), 32'(q[0].op));
        chk("rnd_dest", 32'(bus.out_dest), 32'(q[0].dest));
      end
      v = rnd_vec();
      drive(v, 1'($urandom_range(0, 3) != 0));
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      bus.flush = ($urandom_range(0, 39) == 0);
      acc = bus.in_valid && m_ready;
      pop = (q.size() != 0) && bus.out_ready;
      if (bus.flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          e = model(v);
          q.push_back(e);
        end
      end
      m_ready = (q.size() < 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
